// File: rtl/adc_scan_seq.sv
// ADC channel scan sequencer: walks the enabled channels in ascending order,
// averages 2^AVG_LOG2 conversions per channel and reports each average.
module adc_scan_seq #(
    parameter logic [7:0]  CH_MASK     = 8'hFF,
    parameter int unsigned AVG_LOG2    = 2,
    parameter int unsigned GAP_CYC     = 16,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        continuous,
    input  logic        stop,
    output logic        conv_go,
    output logic [2:0]  addr,
    input  logic [11:0] adc_data,
    input  logic        conv_done,
    output logic [11:0] res_data,
    output logic [2:0]  res_ch,
    output logic        res_valid,
    output logic        busy,
    output logic        timeout_err
);

    localparam int unsigned ACC_W     = 12 + AVG_LOG2;
    localparam int unsigned CNT_W     = AVG_LOG2 + 1;
    localparam int unsigned CNT_MAX   = (1 << AVG_LOG2) - 1;
    localparam int unsigned GAP_W     = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int unsigned GAP_LAST  = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
    localparam int unsigned TMO_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned TMO_LAST  = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    // Lowest enabled channel, resolved at elaboration
    function automatic logic [2:0] first_enabled(input logic [7:0] m);
        logic [2:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    localparam logic [2:0] FIRST_CH = first_enabled(CH_MASK);

    logic [1:0]       state, state_d;
    logic [ACC_W-1:0] acc, acc_d, acc_sum;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [GAP_W-1:0] gap_cnt, gap_d;
    logic [TMO_W-1:0] tmo_cnt, tmo_d;
    logic             cont, cont_d;
    logic             stop_pend, stop_pend_d;
    logic             conv_go_d, res_valid_d, busy_d, timeout_err_d;
    logic [2:0]       addr_d, res_ch_d, nxt_ch;
    logic [11:0]      res_data_d;
    logic             nxt_found;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            acc         <= '0;
            cnt         <= '0;
            gap_cnt     <= '0;
            tmo_cnt     <= '0;
            cont        <= 1'b0;
            stop_pend   <= 1'b0;
            conv_go     <= 1'b0;
            addr        <= '0;
            res_data    <= '0;
            res_ch      <= '0;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            acc         <= acc_d;
            cnt         <= cnt_d;
            gap_cnt     <= gap_d;
            tmo_cnt     <= tmo_d;
            cont        <= cont_d;
            stop_pend   <= stop_pend_d;
            conv_go     <= conv_go_d;
            addr        <= addr_d;
            res_data    <= res_data_d;
            res_ch      <= res_ch_d;
            res_valid   <= res_valid_d;
            busy        <= busy_d;
            timeout_err <= timeout_err_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d       = state;
        acc_d         = acc;
        cnt_d         = cnt;
        gap_d         = gap_cnt;
        tmo_d         = tmo_cnt;
        cont_d        = cont;
        stop_pend_d   = stop_pend;
        addr_d        = addr;
        res_data_d    = res_data;
        res_ch_d      = res_ch;
        res_valid_d   = 1'b0;
        timeout_err_d = timeout_err;
        acc_sum       = acc + ACC_W'(adc_data);

        // Next enabled channel above the current one; falls back to the lowest
        nxt_ch    = FIRST_CH;
        nxt_found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (CH_MASK[i] && (3'(i) > addr)) begin
                nxt_ch    = 3'(i);
                nxt_found = 1'b1;
            end
        end

        case (state)
            S_IDLE: begin
                if (start && !stop && (CH_MASK != 8'h00)) begin
                    cont_d        = continuous;
                    addr_d        = FIRST_CH;
                    acc_d         = '0;
                    cnt_d         = '0;
                    timeout_err_d = 1'b0;
                    stop_pend_d   = 1'b0;
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmo_d = '0;
                if (stop) stop_pend_d = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (conv_done) begin
                    gap_d   = '0;
                    state_d = (GAP_CYC == 0) ? S_ISSUE : S_GAP;
                    if (cnt == CNT_W'(CNT_MAX)) begin
                        res_valid_d = 1'b1;
                        res_data_d  = 12'(acc_sum >> AVG_LOG2);
                        res_ch_d    = addr;
                        acc_d       = '0;
                        cnt_d       = '0;
                        addr_d      = nxt_ch;
                        if (!nxt_found && !cont) state_d = S_IDLE;
                    end else begin
                        acc_d = acc_sum;
                        cnt_d = cnt + CNT_W'(1);
                    end
                    // A stop seen with or before the completion ends the scan afterwards
                    if (stop || stop_pend) state_d = S_IDLE;
                end else if (tmo_cnt == TMO_W'(TMO_LAST)) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    tmo_d = tmo_cnt + TMO_W'(1);
                    if (stop) stop_pend_d = 1'b1;
                end
            end
            S_GAP: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (gap_cnt == GAP_W'(GAP_LAST)) begin
                    state_d = S_ISSUE;
                end else begin
                    gap_d = gap_cnt + GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Any return to idle drops partial averages and pending stops
        if (state_d == S_IDLE) begin
            acc_d       = '0;
            cnt_d       = '0;
            stop_pend_d = 1'b0;
        end

        conv_go_d = (state_d == S_ISSUE);
        busy_d    = (state_d != S_IDLE);
    end

endmodule
